// File: rtl/sram_be_ctrl.sv
// rtl/sram_be_ctrl.sv - single-port byte-lane SRAM with auto-clear, read-valid strobe and error flag
//
// Purpose:
//   Scratch memory that is cleared to zero after every reset before it accepts
//   requests. Writes are masked per byte lane. Reads return data with an
//   explicit valid strobe. Illegal requests raise a one-cycle error strobe.
//
// Ports:
//   clk       in   1    clock; all logic runs on posedge
//   rst       in   1    synchronous active-high reset
//   ready     out  1    1 = requests are sampled this cycle
//   wr_en     in   1    write request
//   rd_en     in   1    read request
//   addr      in   AW   word address
//   be        in   NBE  byte-lane write enables; lane i = dataIn[i*LANE +: LANE]
//   dataIn    in   DAT  write data
//   dataOut   out  DAT  read data; valid when rd_valid=1, held otherwise
//   rd_valid  out  1    one-cycle strobe: dataOut carries an accepted read
//   err       out  1    one-cycle strobe: the previous cycle's request was rejected
//
// Parameters:
//   DAT   data width in bits; must be a multiple of LANE
//   DPTH  number of words (>= 2); need not be a power of two
//   LANE  bits per byte-enable lane
//
// Configuration macro:
//   SRAM_OUT_REG_EN  adds an output register stage, so read latency becomes 2.
//                    The err timing is unchanged.

module sram_be_ctrl #(
    parameter int  DAT  = 16,
    parameter int  DPTH = 16,
    parameter int  LANE = 8,
    localparam int AW   = $clog2(DPTH),
    localparam int NBE  = DAT / LANE
) (
    input  logic           clk,
    input  logic           rst,
    output logic           ready,
    input  logic           wr_en,
    input  logic           rd_en,
    input  logic [AW-1:0]  addr,
    input  logic [NBE-1:0] be,
    input  logic [DAT-1:0] dataIn,
    output logic [DAT-1:0] dataOut,
    output logic           rd_valid,
    output logic           err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DPTH - 1);
    // Widened by one bit so that the range check also holds when DPTH is a power of two.
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DPTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [AW-1:0]  clr_ptr;
    logic           clr_active;
    logic           clr_last;

    logic [DAT-1:0] mem [DPTH];

    logic           in_range;
    logic           wr_acc;
    logic           rd_acc;
    logic           req_bad;

    logic [DAT-1:0] rd_data_s1;
    logic           rd_vld_s1;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    assign clr_last = (clr_ptr == LAST_ADDR);

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_last) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready      = 1'b0;
        clr_active = 1'b0;
        case (state)
            S_CLEAR: clr_active = 1'b1;
            S_RUN:   ready      = 1'b1;
            default: clr_active = 1'b1;
        endcase
    end

    // The clear pointer walks 0..DPTH-1, one word per cycle. Because of this,
    // ready stays low for exactly DPTH cycles after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
        end else if (clr_active) begin
            clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    // Requests are sampled only while ready is high. Outside RUN they are
    // silently ignored and do not raise err.
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign wr_acc   = ready && wr_en && !rd_en && in_range;
    assign rd_acc   = ready && rd_en && !wr_en && in_range;
    assign req_bad  = ready && (wr_en || rd_en) && ((wr_en && rd_en) || !in_range);

    // ------------------------------------------------------------------
    // Memory array
    // ------------------------------------------------------------------
    // The array has no reset branch. Its contents are made known by the
    // clear sweep that follows every reset. A write of be=0 is accepted
    // but changes nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_active) begin
                mem[clr_ptr] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NBE; i++) begin
                    if (be[i]) begin
                        mem[addr][i*LANE +: LANE] <= dataIn[i*LANE +: LANE];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1 and error strobe
    // ------------------------------------------------------------------
    // A read in cycle n+1 sees a write from cycle n, because that write has
    // already landed in the array at the preceding edge. Only one request is
    // taken per cycle, so the array never sees a read and a write together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_s1 <= '0;
            rd_vld_s1  <= 1'b0;
            err        <= 1'b0;
        end else begin
            rd_vld_s1 <= rd_acc;
            err       <= req_bad;
            if (rd_acc) begin
                rd_data_s1 <= mem[addr];
            end
        end
    end

`ifdef SRAM_OUT_REG_EN
    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    // This stage is fully pipelined, so back-to-back reads still give one
    // strobe per read. dataOut holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_vld_s1;
            if (rd_vld_s1) begin
                dataOut <= rd_data_s1;
            end
        end
    end
`else
    assign dataOut  = rd_data_s1;
    assign rd_valid = rd_vld_s1;
`endif

endmodule
